// File: rtl/rr_arbiter_4.sv
// rr_arbiter_4 -- four-requester round-robin arbiter with registered grants.
//
// Outputs a one-hot grant, its 2-bit encoded index and a valid flag. The
// index doubles as the round-robin pointer: after a release the scan restarts
// just above the last owner, so that owner drops to lowest priority.
//
// Optional feature macro: ARB_TIMEOUT_EN
//   defined   -> an 8-bit hold counter force-releases an owner after MAX_HOLD
//                visible grant cycles and pulses tmo for one cycle.
//   undefined -> owners hold the grant for as long as they request; tmo is 0.
module rr_arbiter_4 #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_vld,
    output logic       tmo
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    state_e     state_q;
    logic [3:0] gnt_q;
    logic [1:0] idx_q;
    logic       vld_q;
    logic       tmo_q;

    logic       win_found_d;
    logic [1:0] win_idx_d;
    logic [1:0] scan_cand;
    logic       owner_req;
    logic       hold_expired;

    // Circular scan starting one above the last owner; the first set request wins.
    always_comb begin
        win_found_d = 1'b0;
        win_idx_d   = idx_q;
        scan_cand   = idx_q;
        for (int off = 1; off <= 4; off++) begin
            scan_cand = idx_q + 2'(off);
            if (!win_found_d && req[scan_cand]) begin
                win_found_d = 1'b1;
                win_idx_d   = scan_cand;
            end
        end
    end

    assign owner_req = req[idx_q];

`ifdef ARB_TIMEOUT_EN
    // The counter holds the number of completed grant cycles, so the last
    // allowed cycle is the one where it reads MAX_HOLD-1.
    localparam logic [7:0] HoldLast = 8'(MAX_HOLD - 1);

    logic [7:0] hold_cnt_q;

    assign hold_expired = (hold_cnt_q == HoldLast);

    // Hold counter: cleared when a grant starts, advanced on every kept grant edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_q <= 8'd0;
        end else if (state_q == IDLE) begin
            if (win_found_d) begin
                hold_cnt_q <= 8'd0;
            end
        end else if (owner_req && !hold_expired) begin
            hold_cnt_q <= hold_cnt_q + 8'd1;
        end
    end
`else
    assign hold_expired = 1'b0;
`endif

    // Arbiter FSM with all outputs registered in the same block so the
    // one-hot grant and its index can never disagree.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= 4'b0000;
            idx_q   <= 2'b11;
            vld_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            tmo_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (win_found_d) begin
                        state_q <= GRANT;
                        gnt_q   <= 4'b0001 << win_idx_d;
                        idx_q   <= win_idx_d;
                        vld_q   <= 1'b1;
                    end
                end
                GRANT: begin
                    if (!owner_req) begin
                        state_q <= IDLE;
                        gnt_q   <= 4'b0000;
                        vld_q   <= 1'b0;
                    end else if (hold_expired) begin
                        state_q <= IDLE;
                        gnt_q   <= 4'b0000;
                        vld_q   <= 1'b0;
                        tmo_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= 4'b0000;
                    vld_q   <= 1'b0;
                end
            endcase
        end
    end

    assign gnt     = gnt_q;
    assign gnt_idx = idx_q;
    assign gnt_vld = vld_q;
    assign tmo     = tmo_q;

`ifndef SYNTHESIS
    // Structural invariants of the registered outputs.
    a_max_hold_range : assert property (@(posedge clk)
        (MAX_HOLD >= 2) && (MAX_HOLD <= 255));
    a_vld_matches_gnt : assert property (@(posedge clk) disable iff (!rst_n)
        vld_q == (gnt_q != 4'b0000));
    a_gnt_onehot_of_idx : assert property (@(posedge clk) disable iff (!rst_n)
        vld_q |-> (gnt_q == (4'b0001 << idx_q)));
    a_tmo_only_when_idle : assert property (@(posedge clk) disable iff (!rst_n)
        tmo_q |-> !vld_q);
`endif

endmodule

// File: tb/tb_rr_arbiter_4.sv
// tb_rr_arbiter_4 -- directed bench for rr_arbiter_4 with a behavioural
// reference model compared against the DUT on every falling clock edge.
// Runs in both builds; timeout expectations follow ARB_TIMEOUT_EN.
module tb_rr_arbiter_4;

    localparam int MaxHold = 4;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_vld;
    logic       tmo;

    int errors = 0;
    int checks = 0;
    bit checkEn = 1'b0;

    // Reference model state: owner (-1 = none), last owner, completed grant cycles.
    int mOwner = -1;
    int mPtr   = 3;
    int mShown = 0;
    bit mTmo   = 1'b0;

    rr_arbiter_4 #(
        .MAX_HOLD(MaxHold)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .gnt    (gnt),
        .gnt_idx(gnt_idx),
        .gnt_vld(gnt_vld),
        .tmo    (tmo)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] dutPack();
        return {gnt, gnt_idx, gnt_vld, tmo};
    endfunction

    function automatic logic [7:0] modelPack();
        logic [3:0] g;
        g = 4'b0000;
        if (mOwner >= 0) g = 4'b0001 << mOwner;
        return {g, 2'(mPtr), (mOwner >= 0), mTmo};
    endfunction

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got gnt=%b idx=%b vld=%b tmo=%b, required gnt=%b idx=%b vld=%b tmo=%b",
                     name, act[7:4], act[3:2], act[1], act[0], exp[7:4], exp[3:2], exp[1], exp[0]);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] r, input int cycles);
        req = r;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Behavioural model: scan circularly from the last owner, hold while
    // requesting, release on drop or after MaxHold completed cycles.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mOwner = -1;
                mPtr   = 3;
                mShown = 0;
                mTmo   = 1'b0;
            end else begin
                mTmo = 1'b0;
                if (mOwner < 0) begin
                    for (int k = 1; k <= 4; k++) begin
                        if (mOwner < 0 && req[(mPtr + k) % 4]) begin
                            mOwner = (mPtr + k) % 4;
                            mPtr   = mOwner;
                            mShown = 0;
                        end
                    end
                end else if (!req[mOwner]) begin
                    mOwner = -1;
                end else begin
                    mShown++;
`ifdef ARB_TIMEOUT_EN
                    if (mShown >= MaxHold) begin
                        mOwner = -1;
                        mTmo   = 1'b1;
                    end
`endif
                end
            end
        end
    end

    // Per-cycle comparison of DUT against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (checkEn) checkOutput("model", dutPack(), modelPack());
        end
    end

    // Global watchdog so the run can never hang.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    logic [3:0] rotGnt [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [1:0] rotIdx [5] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00};

    // Directed sequence with hand-computed expectations.
    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;
        repeat (2) @(negedge clk);
        checkEn = 1'b1;
        checkOutput("reset_state", dutPack(), {4'b0000, 2'b11, 1'b0, 1'b0});

        // Single request after reset.
        rst_n = 1'b1;
        applyStimulus(4'b0100, 1);
        checkOutput("single_grant", dutPack(), {4'b0100, 2'b10, 1'b1, 1'b0});
        applyStimulus(4'b0000, 1);
        checkOutput("single_release", dutPack(), {4'b0000, 2'b10, 1'b0, 1'b0});

        // Round-robin rotation with all requesters active.
        doReset();
        for (int k = 0; k < 4; k++) begin
            applyStimulus(4'b1111, 1);
            checkOutput($sformatf("rot_grant%0d", k), dutPack(), {rotGnt[k], rotIdx[k], 1'b1, 1'b0});
            applyStimulus(4'b1111, 1);
            applyStimulus(4'b1111 & ~rotGnt[k], 1);
            checkOutput($sformatf("rot_gap%0d", k), dutPack(), {4'b0000, rotIdx[k], 1'b0, 1'b0});
        end
        applyStimulus(4'b1111, 1);
        checkOutput("rot_grant_wrap", dutPack(), {rotGnt[4], rotIdx[4], 1'b1, 1'b0});
        applyStimulus(4'b0000, 1);

        // Pointer skip: last owner 1, then requests 0 and 3 -> 3 wins.
        applyStimulus(4'b0010, 1);
        checkOutput("skip_owner1", dutPack(), {4'b0010, 2'b01, 1'b1, 1'b0});
        applyStimulus(4'b0000, 1);
        applyStimulus(4'b1001, 1);
        checkOutput("skip_to3", dutPack(), {4'b1000, 2'b11, 1'b1, 1'b0});
        applyStimulus(4'b0000, 1);

        // Timeout behaviour with req=0011 held constantly.
        doReset();
        applyStimulus(4'b0011, 1);
        checkOutput("hold_cycle1", dutPack(), {4'b0001, 2'b00, 1'b1, 1'b0});
        applyStimulus(4'b0011, 3);
        checkOutput("hold_cycle4", dutPack(), {4'b0001, 2'b00, 1'b1, 1'b0});
        applyStimulus(4'b0011, 1);
`ifdef ARB_TIMEOUT_EN
        checkOutput("tmo_pulse0", dutPack(), {4'b0000, 2'b00, 1'b0, 1'b1});
        applyStimulus(4'b0011, 1);
        checkOutput("tmo_next1", dutPack(), {4'b0010, 2'b01, 1'b1, 1'b0});
        applyStimulus(4'b0011, 3);
        applyStimulus(4'b0011, 1);
        checkOutput("tmo_pulse1", dutPack(), {4'b0000, 2'b01, 1'b0, 1'b1});
        applyStimulus(4'b0011, 1);
`else
        checkOutput("hold_cycle5", dutPack(), {4'b0001, 2'b00, 1'b1, 1'b0});
        applyStimulus(4'b0011, 10);
`endif
        checkOutput("hold_back0", dutPack(), {4'b0001, 2'b00, 1'b1, 1'b0});

        // Voluntary release in the last allowed cycle: no timeout pulse.
        applyStimulus(4'b0000, 1);
        applyStimulus(4'b0100, 1);
        checkOutput("coll_grant2", dutPack(), {4'b0100, 2'b10, 1'b1, 1'b0});
        applyStimulus(4'b0100, 3);
        applyStimulus(4'b0000, 1);
        checkOutput("coll_release", dutPack(), {4'b0000, 2'b10, 1'b0, 1'b0});

        // Asynchronous reset in the middle of a grant.
        applyStimulus(4'b0010, 1);
        checkOutput("mid_grant1", dutPack(), {4'b0010, 2'b01, 1'b1, 1'b0});
        #2 rst_n = 1'b0;
        #1 checkOutput("async_reset", dutPack(), {4'b0000, 2'b11, 1'b0, 1'b0});
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(4'b0010, 1);
        checkOutput("post_reset_grant", dutPack(), {4'b0010, 2'b01, 1'b1, 1'b0});
        applyStimulus(4'b0000, 2);

        checkEn = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
